// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown counter with preset load and terminal-count pulse
//
// Purpose: decimal countdown (borrow ripple across DIGITS BCD digits) stepped
// by qualified ticks while in RUN. States IDLE, RUN, EXPIRED.
// Optional feature macro: BCD_DOWN_COUNTER_AUTORELOAD_EN
//   defined   - terminal decrement reloads the preset and keeps running
//   undefined - terminal decrement stops at 0 in EXPIRED
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   load     in   synchronous preset strobe (captures din)
//   din      in   BCD preset, digit 0 in [3:0]
//   start    in   begin/resume counting (needs nonzero count)
//   stop     in   pause counting, hold count
//   tick     in   count-enable strobe, honoured only in RUN
//   dout     out  current count, always valid BCD
//   running  out  state is RUN
//   expired  out  state is EXPIRED
//   done     out  one-cycle pulse on the terminal decrement
//   load_err out  one-cycle pulse when a loaded digit was saturated to 9

module bcd_down_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  running,
    output logic                  expired,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   dout_q;
    logic           done_q;
    logic           load_err_q;
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
    logic [W-1:0]   reload_q;
`endif

    logic [W-1:0]   sat_d;
    logic           sat_any_d;
    logic [W-1:0]   dec_d;
    logic           is_one_d;
    logic           is_zero_d;

    // Saturate each preset digit to 9 and flag if any digit was out of range.
    always_comb begin
        sat_d     = '0;
        sat_any_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                sat_d[4*i +: 4] = 4'd9;
                sat_any_d       = 1'b1;
            end else begin
                sat_d[4*i +: 4] = din[4*i +: 4];
            end
        end
    end

    // BCD decrement: a zero digit wraps to 9 and keeps the borrow moving up;
    // the first nonzero digit absorbs it.
    always_comb begin
        logic borrow;
        dec_d  = dout_q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (dout_q[4*i +: 4] == 4'd0) begin
                    dec_d[4*i +: 4] = 4'd9;
                end else begin
                    dec_d[4*i +: 4] = dout_q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    assign is_one_d  = (dout_q == W'(1));
    assign is_zero_d = (dout_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dout_q     <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
            reload_q   <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (load) begin
                dout_q     <= sat_d;
                state_q    <= IDLE;
                load_err_q <= sat_any_d;
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
                reload_q   <= sat_d;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        // stop outranks start; a zero count cannot be started
                        if (!stop && start && !is_zero_d) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (tick) begin
                            if (is_one_d) begin
                                done_q  <= 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
                                dout_q  <= reload_q;
`else
                                dout_q  <= '0;
                                state_q <= EXPIRED;
`endif
                            end else begin
                                dout_q <= dec_d;
                            end
                        end
                    end
                    EXPIRED: begin
                        // held at 0 until load or rst
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dout     = dout_q;
    assign done     = done_q;
    assign load_err = load_err_q;
    assign running  = (state_q == RUN);
    assign expired  = (state_q == EXPIRED);

endmodule
